milano_pipe_stage: RTL and testbench
====================================

# milano_pipe_stage

Parametrised valid/ready pipeline stage for the milano core, the generalised successor of the fixed ID/EX register. It carries an opaque packed payload between any two stages (IF/ID, ID/EX, EX/WB) with per-stage backpressure, synchronous flush, optional skid buffering for a registered ready path, and a saturating stall counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 74, payload width in bits; the ID/EX instance packs rd_addr, rd_wr_en, rs1_data, rs2_data and alu_operate.
- SKID, 1, selects the buffer mode:
  - 0: single register; in_ready_o is combinational from out_ready_i.
  - 1: two-entry main+skid buffer; in_ready_o is registered.
- ZERO_BUBBLE, 1, if 1, out_data_o is forced to 0 whenever out_valid_o=0.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous kill of all held entries
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  stage can accept
- in_data_i  in  DATA_W  upstream payload
- out_valid_o  out  1  payload valid to downstream
- out_ready_i  in  1  downstream accepts
- out_data_o  out  DATA_W  payload to downstream
- cnt_clr_i  in  1  synchronous clear of stall counter
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles

## Operation
- Handshakes:
  - Input transfer occurs when in_valid_i && in_ready_o.
  - Output transfer occurs when out_valid_o && out_ready_i.
  - Payload order is strictly FIFO.
- SKID=0:
  - in_ready_o = !out_valid_o || out_ready_i.
  - On an input transfer, the register loads in_data_i and valid is set.
  - On an output transfer with no input transfer, valid clears.
- SKID=1 state machine (pipe_state_e): EMPTY, BUSY (main valid), FULL (main+skid valid). in_ready_o = (state != FULL).
  - EMPTY: input transfer -> BUSY (main loads).
  - BUSY:
    - input and output transfer -> BUSY (main reloads);
    - input only -> FULL (skid loads);
    - output only -> EMPTY.
  - FULL: output transfer -> BUSY (main takes skid). No input transfer is possible in FULL.
- out_data_o/out_valid_o always come from the main register.
- flush_i, highest priority:
  - Next state is EMPTY; all valids clear.
  - An input transfer in the same cycle completes the handshake, but its payload is discarded.
  - Data registers are not cleared.
- Stall counter:
  - Increments when out_valid_o && !out_ready_i.
  - Saturates at all-ones with no wrap.
  - cnt_clr_i wins over increment.
  - Not affected by flush_i.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, stall_cnt_o=0, state EMPTY.
  - SKID=1: in_ready_o=1 during and after reset.
  - SKID=0: in_ready_o=1, since the stage is empty.
- Latency: 1 cycle from input transfer to out_valid_o.
- Throughput: 1 payload/cycle while out_ready_i=1, in both modes.
- SKID=1 backpressure: after out_ready_i falls, at most one further payload is absorbed into skid. in_ready_o falls in the cycle after that input transfer.
- SKID=1 release: after out_ready_i rises in FULL, in_ready_o is 1 the following cycle.
- Flush: out_valid_o=0 the cycle after flush_i=1. A payload presented the cycle after flush is accepted normally.
- Reset mid-operation: all valids clear immediately (asynchronous assertion); held payloads are lost.

## Structure
- milano_pkg holds:
  - pipe_state_e enum (EMPTY, BUSY, FULL);
  - ID_EX_DATA_W constant;
  - packed struct id_ex_payload_t, used by the instantiating stage for packing and unpacking.
- Single module. SKID=0/1 are selected by generate branches; no sub-module is needed.

## Test plan
- Streaming: SKID=1, out_ready_i=1, send 0x1..0x8 back-to-back -> out_data_o shows 0x1..0x8 on consecutive cycles starting 1 cycle later, with in_ready_o constantly 1.
- Backpressure: SKID=1, drop out_ready_i while streaming 0xA,0xB,0xC -> state FULL holding 0xA/0xB, in_ready_o=0, stall_cnt_o increments each cycle. Raise out_ready_i -> 0xA,0xB,0xC delivered in order with none lost or duplicated.
- Combinational ready: SKID=0, out_valid_o=1 with out_ready_i=1 -> in_ready_o=1 the same cycle. With out_ready_i=0 -> in_ready_o=0.
- Flush: FULL state, assert flush_i with in_valid_i=1 (payload 0xDEAD) -> next cycle out_valid_o=0, out_data_o=0 (ZERO_BUBBLE=1), and 0xDEAD is never output.
- Counter: CNT_W=4, stall for 20 cycles -> stall_cnt_o=15. Assert cnt_clr_i while still stalled -> 0 the next cycle, then increments again.
- Reset: assert rst_ni=0 asynchronously mid-stream -> out_valid_o=0 and stall_cnt_o=0 without waiting for a clock edge, and in_ready_o=1.

Source files
------------

// File: rtl/milano_pkg.sv
// milano_pkg: shared pipeline types for the milano core stages.
package milano_pkg;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_e;

    // ID/EX payload packed as one opaque word for milano_pipe_stage.
    typedef struct packed {
        logic [4:0]  rd_addr;
        logic        rd_wr_en;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [3:0]  alu_operate;
    } id_ex_payload_t;

    localparam int ID_EX_DATA_W = $bits(id_ex_payload_t);

endpackage

// File: rtl/milano_pipe_stage.sv
// milano_pipe_stage: valid/ready pipeline register with optional skid buffer,
// synchronous flush and a saturating stall counter.
module milano_pipe_stage
    import milano_pkg::*;
#(
    parameter int DATA_W      = ID_EX_DATA_W,
    parameter int SKID        = 1,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              valid;
    logic              in_ready;
    logic              in_xfer;
    logic              out_xfer;
    logic [DATA_W-1:0] main_q;
    logic [CNT_W-1:0]  cnt_q;

    assign in_xfer  = in_valid_i && in_ready;
    assign out_xfer = valid && out_ready_i;

    generate
        if (SKID == 0) begin : g_reg
            logic valid_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else begin
                    if (in_xfer) main_q <= in_data_i;
                    valid_q <= flush_i ? 1'b0 : in_xfer ? 1'b1 : out_xfer ? 1'b0 : valid_q;
                end
            end
            assign in_ready = !valid_q || out_ready_i;
            assign valid    = valid_q;
        end else begin : g_skid
            pipe_state_e       state_q, state_d;
            logic [DATA_W-1:0] skid_q;
            logic              load_main, load_skid;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) state_q <= EMPTY;
                else         state_q <= state_d;
            end
            // Main reloads from skid when draining FULL, otherwise from the input.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    main_q <= '0;
                    skid_q <= '0;
                end else begin
                    if (load_main) main_q <= (state_q == FULL) ? skid_q : in_data_i;
                    if (load_skid) skid_q <= in_data_i;
                end
            end
            always_comb begin
                state_d   = state_q;
                load_main = 1'b0;
                load_skid = 1'b0;
                case (state_q)
                    EMPTY: if (in_xfer) begin
                        state_d   = BUSY;
                        load_main = 1'b1;
                    end
                    BUSY: if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                    FULL: if (out_xfer) begin
                        state_d   = BUSY;
                        load_main = 1'b1;
                    end
                    default: state_d = EMPTY;
                endcase
                if (flush_i) state_d = EMPTY;
            end
            assign in_ready = state_q != FULL;
            assign valid    = state_q != EMPTY;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                              cnt_q <= '0;
        else if (cnt_clr_i)                       cnt_q <= '0;
        else if (valid && !out_ready_i && ~&cnt_q) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = valid;
    assign out_data_o  = (ZERO_BUBBLE != 0 && !valid) ? '0 : main_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_milano_pipe_stage.sv
// tb_milano_pipe_stage: scoreboard bench driving a skid instance (4-bit counter)
// and a single-register instance with the same stimulus.
module tb_milano_pipe_stage;
    import milano_pkg::*;

    localparam int W = ID_EX_DATA_W;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
    logic [W-1:0] in_data = '0;
    logic rdy_a, vld_a, rdy_b, vld_b;
    logic [W-1:0] dat_a, dat_b;
    logic [3:0] cnt_a;
    logic [15:0] cnt_b;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int exp_cnt_a = 0, exp_cnt_b = 0;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    milano_pipe_stage #(.DATA_W(W), .SKID(1), .ZERO_BUBBLE(1), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy_a),
        .in_data_i(in_data), .out_valid_o(vld_a), .out_ready_i(out_ready), .out_data_o(dat_a),
        .cnt_clr_i(cnt_clr), .stall_cnt_o(cnt_a));

    milano_pipe_stage #(.DATA_W(W), .SKID(0), .ZERO_BUBBLE(1), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy_b),
        .in_data_i(in_data), .out_valid_o(vld_b), .out_ready_i(out_ready), .out_data_o(dat_b),
        .cnt_clr_i(cnt_clr), .stall_cnt_o(cnt_b));

    task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Monitor: compare against the model's held payload queue, then retire what leaves.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_in_ready", W'(rdy_a), W'(qa.size() < 2));
            chk("a_out_valid", W'(vld_a), W'(qa.size() > 0));
            chk("a_out_data", dat_a, qa.size() > 0 ? qa[0] : '0);
            chk("a_stall_cnt", W'(cnt_a), W'(exp_cnt_a));
            chk("b_in_ready", W'(rdy_b), W'(qb.size() == 0 || out_ready));
            chk("b_out_valid", W'(vld_b), W'(qb.size() > 0));
            chk("b_out_data", dat_b, qb.size() > 0 ? qb[0] : '0);
            chk("b_stall_cnt", W'(cnt_b), W'(exp_cnt_b));
            if (cnt_clr) exp_cnt_a = 0;
            else if (qa.size() > 0 && !out_ready && exp_cnt_a < 15) exp_cnt_a++;
            if (cnt_clr) exp_cnt_b = 0;
            else if (qb.size() > 0 && !out_ready && exp_cnt_b < 65535) exp_cnt_b++;
            if (qa.size() > 0 && out_ready) void'(qa.pop_front());
            if (qb.size() > 0 && out_ready) void'(qb.pop_front());
        end
    end

    task automatic step(logic v, logic [W-1:0] d, logic ordy, logic fl, logic clr);
        logic xa, xb;
        in_valid = v; in_data = d; out_ready = ordy; flush = fl; cnt_clr = clr;
        @(negedge clk);
        xa = v && rdy_a;
        xb = v && rdy_b;
        @(posedge clk);
        if (fl) begin
            qa.delete();
            qb.delete();
        end else begin
            if (xa) qa.push_back(d);
            if (xb) qb.push_back(d);
        end
        #1;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, W'('hA), 1'b1, 1'b0, 1'b0);
        step(1'b1, W'('hB), 1'b0, 1'b0, 1'b0);
        step(1'b1, W'('hC), 1'b0, 1'b0, 1'b0);
        step(1'b1, W'('hC), 1'b0, 1'b0, 1'b0);
        step(1'b1, W'('hC), 1'b1, 1'b0, 1'b0);
        step(1'b1, W'('hC), 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, W'('h11), 1'b0, 1'b0, 1'b1);
        step(1'b1, W'('h22), 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("a_stall_saturated", W'(cnt_a), W'(15));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("a_stall_cleared", W'(cnt_a), W'(0));
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("a_stall_restart", W'(cnt_a), W'(1));
        step(1'b1, W'('hDEAD), 1'b0, 1'b1, 1'b0);
        chk("a_flush_valid", W'(vld_a), W'(0));
        chk("a_flush_data", dat_a, '0);
        chk("b_flush_valid", W'(vld_b), W'(0));
        step(1'b1, W'('h55), 1'b1, 1'b0, 1'b0);
        chk("a_after_flush", dat_a, W'('h55));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (400)
            step($urandom_range(0, 3) != 0, W'({$urandom(), $urandom(), $urandom()}),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
        step(1'b1, W'('h77), 1'b0, 1'b0, 1'b0);
        step(1'b1, W'('h78), 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("a_rst_valid", W'(vld_a), W'(0));
        chk("a_rst_cnt", W'(cnt_a), W'(0));
        chk("a_rst_ready", W'(rdy_a), W'(1));
        chk("b_rst_valid", W'(vld_b), W'(0));
        chk("b_rst_cnt", W'(cnt_b), W'(0));
        chk("b_rst_ready", W'(rdy_b), W'(1));
        qa.delete();
        qb.delete();
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) step(1'b1, W'(i + 'h100), 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
